// File: rtl/apb_slave_regs_if.sv
// apb_slave_regs_if: APB bus between a master and the apb_slave_regs completer
interface apb_slave_regs_if #(
  parameter int DATA = 32,
  parameter int ADDR = 32
);
  logic psel;
  logic penable;
  logic pwrite;
  logic [ADDR-1:0] paddr;
  logic [DATA-1:0] pwdata;
  logic [DATA/8-1:0] pstrb;
  logic [DATA-1:0] prdata;
  logic pready;
  logic pslverr;
  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input prdata, pready, pslverr
  );
  modport slave (
    input psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB completer, DEPTH-word register file, WAIT_CYCLES wait states, pslverr on out-of-range address
// Define APB_SLV_PSTRB_EN to make writes honour pstrb byte strobes.
module apb_slave_regs #(
  parameter int DATA = 32,
  parameter int ADDR = 32,
  parameter int DEPTH = 16,
  parameter int WAIT_CYCLES = 1
) (
  input logic pclk,
  input logic preset,
  apb_slave_regs_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, phase;
  logic [DATA-1:0] mem [DEPTH];
  logic [IW-1:0] idx_l, rd_idx;
  logic [DATA-1:0] wdata_l, nw, rdata_q;
  logic [3:0] wcnt;
  logic wr_l, err_l, err_now, rd_err, rd_wr, finish, ready_q, slverr_q;
`ifdef APB_SLV_PSTRB_EN
  logic [DATA/8-1:0] strb_l;
  always_comb begin
    nw = mem[idx_l];
    for (int i = 0; i < DATA/8; i++) nw[8*i +: 8] = strb_l[i] ? wdata_l[8*i +: 8] : mem[idx_l][8*i +: 8];
  end
`else
  assign nw = wdata_l;
`endif
  // SETUP is the cycle the master presents psel without penable while we sit idle
  assign phase = (state == ACCESS) ? ACCESS : (bus.psel && !bus.penable) ? SETUP : IDLE;
  assign err_now = bus.paddr >= ADDR'(DEPTH);
  assign rd_idx = (phase == SETUP) ? bus.paddr[IW-1:0] : idx_l;
  assign rd_err = (phase == SETUP) ? err_now : err_l;
  assign rd_wr = (phase == SETUP) ? bus.pwrite : wr_l;
  // outputs are registered, so the completion cycle is armed one edge ahead
  assign finish = (phase == SETUP) ? (WAIT_CYCLES == 0) : (phase == ACCESS && !ready_q && bus.psel && wcnt == 4'd1);
  assign bus.prdata = rdata_q;
  assign bus.pready = ready_q;
  assign bus.pslverr = slverr_q;
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
      wcnt <= '0;
      idx_l <= '0;
      wdata_l <= '0;
      wr_l <= 1'b0;
      err_l <= 1'b0;
`ifdef APB_SLV_PSTRB_EN
      strb_l <= '0;
`endif
      rdata_q <= '0;
      ready_q <= 1'b0;
      slverr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ready_q <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q <= '0;
      case (phase)
        SETUP: begin
          state <= ACCESS;
          idx_l <= bus.paddr[IW-1:0];
          wr_l <= bus.pwrite;
          err_l <= err_now;
          wdata_l <= bus.pwdata;
`ifdef APB_SLV_PSTRB_EN
          strb_l <= bus.pstrb;
`endif
          wcnt <= 4'(WAIT_CYCLES);
        end
        ACCESS: begin
          if (ready_q) begin
            state <= IDLE;
            if (bus.psel && wr_l && !err_l) mem[idx_l] <= nw;
          end else if (!bus.psel) begin
            state <= IDLE;
            wcnt <= '0;
          end else wcnt <= wcnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
      if (finish) begin
        ready_q <= 1'b1;
        slverr_q <= rd_err;
        rdata_q <= (rd_wr || rd_err) ? '0 : mem[rd_idx];
      end
    end
  end
endmodule

// File: tb/tb_apb_slave_regs.sv
// tb_apb_slave_regs: directed + random APB transfers on a 1-wait and a 0-wait instance against an array model
module tb_apb_slave_regs;
  localparam int W0 = 1;
  localparam int W1 = 0;
`ifdef APB_SLV_PSTRB_EN
  localparam logic [31:0] STRB_EXP = 32'hFF00FF00;
`else
  localparam logic [31:0] STRB_EXP = 32'h0;
`endif
  logic clk = 1'b0;
  logic preset = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [31:0] mdl [2][16];
  apb_slave_regs_if #(.DATA(32), .ADDR(32)) b0 ();
  apb_slave_regs_if #(.DATA(32), .ADDR(32)) b1 ();
  apb_slave_regs #(.DATA(32), .ADDR(32), .DEPTH(16), .WAIT_CYCLES(W0)) dut0 (.pclk(clk), .preset(preset), .bus(b0));
  apb_slave_regs #(.DATA(32), .ADDR(32), .DEPTH(16), .WAIT_CYCLES(W1)) dut1 (.pclk(clk), .preset(preset), .bus(b1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit u, input logic s, input logic e, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    if (u) begin
      b1.psel = s; b1.penable = e; b1.pwrite = w; b1.paddr = a; b1.pwdata = d; b1.pstrb = st;
    end else begin
      b0.psel = s; b0.penable = e; b0.pwrite = w; b0.paddr = a; b0.pwdata = d; b0.pstrb = st;
    end
  endtask
  function automatic logic [33:0] outs(input bit u);
    return u ? {b1.pready, b1.pslverr, b1.prdata} : {b0.pready, b0.pslverr, b0.prdata};
  endfunction
  task automatic clear_model();
    for (int u = 0; u < 2; u++) for (int i = 0; i < 16; i++) mdl[u][i] = 32'h0;
  endtask
  task automatic xfer(input bit u, input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                      output logic [31:0] rd, output logic er, output int waits);
    logic [33:0] o;
    drive(u, 1'b1, 1'b0, wr, a, d, st);
    chk("idle_out", outs(u), 34'h0);
    @(negedge clk);
    drive(u, 1'b1, 1'b1, wr, $urandom, $urandom, st);
    waits = 0;
    o = outs(u);
    while (!o[33] && waits < 40) begin
      waits++;
      @(negedge clk);
      drive(u, 1'b1, 1'b1, wr, $urandom, $urandom, st);
      o = outs(u);
    end
    chk("pready", o[33], 1'b1);
    rd = o[31:0];
    er = o[32];
    @(negedge clk);
  endtask
  task automatic op(input bit u, input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    logic [31:0] rd, exp;
    logic er;
    int wt;
    bit bad;
    bad = a >= 16;
    exp = bad ? 32'h0 : mdl[u][a[3:0]];
    xfer(u, wr, a, d, st, rd, er, wt);
    chk("waits", wt, u ? W1 : W0);
    chk("pslverr", er, bad);
    if (!wr) chk("prdata", rd, exp);
    if (wr && !bad) begin
`ifdef APB_SLV_PSTRB_EN
      for (int i = 0; i < 4; i++) if (st[i]) mdl[u][a[3:0]][8*i +: 8] = d[8*i +: 8];
`else
      mdl[u][a[3:0]] = d;
`endif
    end
  endtask
  initial begin
    logic [31:0] rd;
    logic er;
    int wt;
    clear_model();
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_out0", outs(0), 34'h0);
    chk("reset_out1", outs(1), 34'h0);
    preset = 1'b0;
    @(negedge clk);
    op(0, 0, 32'h05, 0, 4'hF);
    op(0, 1, 32'h0A, 32'hAAAA, 4'hF);
    op(0, 1, 32'h0B, 32'hBBBB, 4'hF);
    op(0, 1, 32'h0C, 32'hCCCC, 4'hF);
    xfer(0, 0, 32'h0A, 0, 4'hF, rd, er, wt);
    chk("rb_0a", rd, 32'hAAAA);
    op(0, 0, 32'h0B, 0, 4'hF);
    op(0, 0, 32'h0C, 0, 4'hF);
    op(0, 1, 32'h20, 32'h1234, 4'hF);
    op(0, 0, 32'h20, 0, 4'hF);
    op(0, 0, 32'h00, 0, 4'hF);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 1, 1, 32'h02, 32'h77, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("penable_idle", outs(0), 34'h0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    op(0, 0, 32'h02, 0, 4'hF);
    op(1, 1, 32'h03, 32'hDEAD, 4'hF);
    xfer(1, 0, 32'h03, 0, 4'hF, rd, er, wt);
    chk("b2b_data", rd, 32'hDEAD);
    chk("b2b_waits", wt, 0);
    op(0, 1, 32'h01, 32'hFFFFFFFF, 4'hF);
    op(0, 1, 32'h01, 32'h00000000, 4'b0101);
    xfer(0, 0, 32'h01, 0, 4'hF, rd, er, wt);
    chk("pstrb_read", rd, STRB_EXP);
    chk("pstrb_model", rd, mdl[0][1]);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 0, 1, 32'h04, 32'h55, 4'hF);
    @(negedge clk);
    drive(0, 1, 1, 1, 32'h04, 32'h55, 4'hF);
    @(negedge clk);
    chk("rst_pre_ready", outs(0), {2'b10, 32'h0});
    #2 preset = 1'b1;
    #1 chk("rst_async_out", outs(0), 34'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    preset = 1'b0;
    clear_model();
    @(negedge clk);
    op(0, 0, 32'h04, 0, 4'hF);
    op(0, 0, 32'h0A, 0, 4'hF);
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 40; n++) begin
        op(u[0], 1'($urandom_range(0, 1)), 32'($urandom_range(0, 19)), $urandom, 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0) begin
          drive(u[0], 0, 0, 0, 0, 0, 0);
          @(negedge clk);
        end
      end
      for (int i = 0; i < 16; i++) op(u[0], 1'b0, 32'(i), 0, 4'hF);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
